// File: rtl/axis_xbar_rr.sv
// AXI-Stream crossbar. Packets are routed by tdest, each output has its own round-robin
// arbiter with packet locking and a registered output stage, and bad destinations are dropped and counted.
module axis_xbar_rr #(
  parameter int S_COUNT    = 3,
  parameter int M_COUNT    = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 3,
  parameter int ID_WIDTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_tdata,
  input  logic [S_COUNT-1:0]              s_tvalid,
  output logic [S_COUNT-1:0]              s_tready,
  input  logic [S_COUNT-1:0]              s_tlast,
  input  logic [S_COUNT*DEST_WIDTH-1:0]   s_tdest,
  output logic [M_COUNT*DATA_WIDTH-1:0]   m_tdata,
  output logic [M_COUNT-1:0]              m_tvalid,
  input  logic [M_COUNT-1:0]              m_tready,
  output logic [M_COUNT-1:0]              m_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]     m_tid,
  output logic [15:0]                     drop_cnt
);

  logic [S_COUNT-1:0]    r_in_busy;
  logic [DEST_WIDTH-1:0] r_in_route [S_COUNT];
  logic [M_COUNT-1:0]    r_owned;
  logic [ID_WIDTH-1:0]   r_owner [M_COUNT];
  logic [ID_WIDTH-1:0]   r_ptr [M_COUNT];
  logic [M_COUNT-1:0]    r_m_tvalid;
  logic [M_COUNT-1:0]    r_m_tlast;
  logic [DATA_WIDTH-1:0] r_m_tdata [M_COUNT];
  logic [ID_WIDTH-1:0]   r_m_tid [M_COUNT];
  logic [15:0]           r_drop_cnt;

  logic [DEST_WIDTH-1:0] w_route [S_COUNT];
  logic [S_COUNT-1:0]    w_drop;
  logic [S_COUNT-1:0]    w_req [M_COUNT];
  logic [M_COUNT-1:0]    w_free;
  logic [M_COUNT-1:0]    w_gnt_vld;
  logic [M_COUNT-1:0]    w_accept;
  logic [ID_WIDTH-1:0]   w_gnt [M_COUNT];
  logic [DATA_WIDTH-1:0] w_mux_data [M_COUNT];
  logic [M_COUNT-1:0]    w_mux_last;
  logic [S_COUNT-1:0]    w_s_tready;
  logic [15:0]           w_drop_next;

  // A port mid-packet follows its latched route; a head beat follows its own tdest.
  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      w_route[i] = r_in_busy[i] ? r_in_route[i] : s_tdest[i*DEST_WIDTH +: DEST_WIDTH];
      w_drop[i]  = (int'(w_route[i]) >= M_COUNT);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any condition, so no latch can be inferred.
    for (int j = 0; j < M_COUNT; j++) begin
      logic found;
      found         = 1'b0;
      w_req[j]      = '0;
      w_free[j]     = !r_m_tvalid[j] || m_tready[j];
      w_gnt_vld[j]  = 1'b0;
      w_gnt[j]      = '0;
      w_mux_data[j] = '0;
      w_mux_last[j] = 1'b0;
      for (int i = 0; i < S_COUNT; i++)
        w_req[j][i] = s_tvalid[i] && !w_drop[i] && (int'(w_route[i]) == j);
      if (r_owned[j]) begin
        w_gnt[j] = r_owner[j];
        for (int i = 0; i < S_COUNT; i++)
          if (int'(r_owner[j]) == i) w_gnt_vld[j] = w_req[j][i];
      end else begin
        // Two passes emulate a scan starting just above the pointer and wrapping.
        for (int i = 0; i < S_COUNT; i++)
          if (!found && w_req[j][i] && i > int'(r_ptr[j])) begin
            found    = 1'b1;
            w_gnt[j] = ID_WIDTH'(i);
          end
        for (int i = 0; i < S_COUNT; i++)
          if (!found && w_req[j][i] && i <= int'(r_ptr[j])) begin
            found    = 1'b1;
            w_gnt[j] = ID_WIDTH'(i);
          end
        w_gnt_vld[j] = found;
      end
      w_accept[j] = w_gnt_vld[j] && w_free[j];
      for (int i = 0; i < S_COUNT; i++)
        if (int'(w_gnt[j]) == i) begin
          w_mux_data[j] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          w_mux_last[j] = s_tlast[i];
        end
    end
  end

  always_comb begin
    w_drop_next = r_drop_cnt;
    for (int i = 0; i < S_COUNT; i++) begin
      w_s_tready[i] = !rst && w_drop[i];
      for (int j = 0; j < M_COUNT; j++)
        if (!rst && w_accept[j] && int'(w_gnt[j]) == i) w_s_tready[i] = 1'b1;
      if (s_tvalid[i] && w_s_tready[i] && w_drop[i] && s_tlast[i] && w_drop_next != 16'hFFFF)
        w_drop_next = w_drop_next + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_busy  <= '0;
      r_owned    <= '0;
      r_m_tvalid <= '0;
      r_m_tlast  <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < S_COUNT; i++) r_in_route[i] <= '0;
      for (int j = 0; j < M_COUNT; j++) begin
        r_owner[j]   <= '0;
        r_ptr[j]     <= ID_WIDTH'(S_COUNT - 1);
        r_m_tdata[j] <= '0;
        r_m_tid[j]   <= '0;
      end
    end else begin
      for (int i = 0; i < S_COUNT; i++)
        if (s_tvalid[i] && w_s_tready[i]) begin
          r_in_busy[i] <= !s_tlast[i];
          if (!r_in_busy[i]) r_in_route[i] <= s_tdest[i*DEST_WIDTH +: DEST_WIDTH];
        end
      for (int j = 0; j < M_COUNT; j++) begin
        if (w_accept[j]) begin
          r_m_tvalid[j] <= 1'b1;
          r_m_tdata[j]  <= w_mux_data[j];
          r_m_tlast[j]  <= w_mux_last[j];
          r_m_tid[j]    <= w_gnt[j];
          r_owned[j]    <= !w_mux_last[j];
          r_owner[j]    <= w_gnt[j];
          if (w_mux_last[j]) r_ptr[j] <= w_gnt[j];
        end else if (m_tready[j]) begin
          r_m_tvalid[j] <= 1'b0;
        end
      end
      r_drop_cnt <= w_drop_next;
    end
  end

  for (genvar j = 0; j < M_COUNT; j++) begin : g_out
    assign m_tdata[j*DATA_WIDTH +: DATA_WIDTH] = r_m_tdata[j];
    assign m_tid[j*ID_WIDTH +: ID_WIDTH]       = r_m_tid[j];
  end

  assign m_tvalid = r_m_tvalid;
  assign m_tlast  = r_m_tlast;
  assign s_tready = w_s_tready;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_axis_xbar_rr.sv
// Directed bench for axis_xbar_rr: a cycle table (inputs plus expected outputs)
// followed by hand-written sequences for drop-counter saturation and mid-packet reset.
module tb_axis_xbar_rr;

  logic         clk = 1'b0;
  logic         rst;
  logic [95:0]  s_tdata;
  logic [2:0]   s_tvalid, s_tready, s_tlast;
  logic [8:0]   s_tdest;
  logic [159:0] m_tdata;
  logic [4:0]   m_tvalid, m_tready, m_tlast;
  logic [9:0]   m_tid;
  logic [15:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_xbar_rr dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tdest(s_tdest),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tid(m_tid), .drop_cnt(drop_cnt)
  );

  // One row = inputs held for one cycle, and what must be seen at the falling edge of that cycle.
  typedef struct {
    logic         rst;
    logic [2:0]   vld, lst;
    logic [8:0]   dst;
    logic [95:0]  dat;
    logic [4:0]   rdy;
    logic [2:0]   e_srdy;
    logic [4:0]   e_mvld, e_mlast;
    logic [9:0]   e_mtid;
    logic [159:0] e_mdat;
    logic [15:0]  e_drop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [2:0] vld, input logic [2:0] lst,
                     input logic [8:0] dst, input logic [95:0] dat, input logic [4:0] rdy,
                     input logic [2:0] e_srdy, input logic [4:0] e_mvld, input logic [4:0] e_mlast,
                     input logic [9:0] e_mtid, input logic [159:0] e_mdat, input logic [15:0] e_drop);
    vec_t v;
    v.rst = r; v.vld = vld; v.lst = lst; v.dst = dst; v.dat = dat; v.rdy = rdy;
    v.e_srdy = e_srdy; v.e_mvld = e_mvld; v.e_mlast = e_mlast;
    v.e_mtid = e_mtid; v.e_mdat = e_mdat; v.e_drop = e_drop;
    tbl.push_back(v);
  endtask

  function automatic logic [159:0] at(input int j, input logic [31:0] v);
    logic [159:0] r;
    r = '0;
    r[j*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [9:0] tid(input int j, input logic [1:0] t);
    logic [9:0] r;
    r = '0;
    r[j*2 +: 2] = t;
    return r;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] vld, input logic [2:0] lst,
                       input logic [8:0] dst, input logic [95:0] dat, input logic [4:0] rdy);
    rst = r; s_tvalid = vld; s_tlast = lst; s_tdest = dst; s_tdata = dat; m_tready = rdy;
  endtask

  localparam logic [8:0] D444 = {3'd4, 3'd4, 3'd4};

  initial begin
    drive(1'b1, 3'b000, 3'b000, '0, '0, 5'h1f);
    @(posedge clk); #1;

    // Reset held with all inputs valid.
    for (int k = 0; k < 3; k++)
      add(1, 3'b111, 3'b111, D444, {32'h2, 32'h1, 32'h0}, 5'h1f, 3'b000, 5'b0, 5'b0, 10'h0, '0, 16'd0);
    // Round robin on output 4: expected tid order 0,0,1,1,2,2,0,0.
    add(0, 3'b111, 3'b000, D444, {32'h2C00, 32'h1B00, 32'h0A00}, 5'h1f, 3'b001, 5'b00000, 5'b00000, 10'h0, '0, 16'd0);
    add(0, 3'b111, 3'b001, D444, {32'h2C00, 32'h1B00, 32'h0A01}, 5'h1f, 3'b001, 5'b10000, 5'b00000, tid(4, 0), at(4, 32'h0A00), 16'd0);
    add(0, 3'b111, 3'b000, D444, {32'h2C00, 32'h1B00, 32'h0A10}, 5'h1f, 3'b010, 5'b10000, 5'b10000, tid(4, 0), at(4, 32'h0A01), 16'd0);
    add(0, 3'b111, 3'b010, D444, {32'h2C00, 32'h1B01, 32'h0A10}, 5'h1f, 3'b010, 5'b10000, 5'b00000, tid(4, 1), at(4, 32'h1B00), 16'd0);
    add(0, 3'b101, 3'b000, D444, {32'h2C00, 32'h0, 32'h0A10},    5'h1f, 3'b100, 5'b10000, 5'b10000, tid(4, 1), at(4, 32'h1B01), 16'd0);
    add(0, 3'b101, 3'b100, D444, {32'h2C01, 32'h0, 32'h0A10},    5'h1f, 3'b100, 5'b10000, 5'b00000, tid(4, 2), at(4, 32'h2C00), 16'd0);
    add(0, 3'b001, 3'b000, D444, {32'h0, 32'h0, 32'h0A10},       5'h1f, 3'b001, 5'b10000, 5'b10000, tid(4, 2), at(4, 32'h2C01), 16'd0);
    add(0, 3'b001, 3'b001, D444, {32'h0, 32'h0, 32'h0A11},       5'h1f, 3'b001, 5'b10000, 5'b00000, tid(4, 0), at(4, 32'h0A10), 16'd0);
    add(0, 3'b000, 3'b000, D444, '0,                             5'h1f, 3'b000, 5'b10000, 5'b10000, tid(4, 0), at(4, 32'h0A11), 16'd0);
    // Parallel single-beat packets: in0->out0, in1->out3, in2->out1.
    add(0, 3'b111, 3'b111, {3'd1, 3'd3, 3'd0}, {32'hC1, 32'hB3, 32'hA0}, 5'h1f, 3'b111, 5'b00000, 5'b00000, 10'h0, '0, 16'd0);
    add(0, 3'b000, 3'b000, D444, '0, 5'h1f, 3'b000, 5'b01011, 5'b01011, tid(1, 2) | tid(3, 1),
        at(0, 32'hA0) | at(1, 32'hC1) | at(3, 32'hB3), 16'd0);
    // Backpressure: 4-beat packet in1->out2 with m_tready[2] low for four cycles.
    add(0, 3'b010, 3'b000, {3'd0, 3'd2, 3'd0}, {32'h0, 32'h1D01, 32'h0}, 5'h1f,     3'b010, 5'b00000, 5'b00000, 10'h0, '0, 16'd0);
    for (int k = 0; k < 4; k++)
      add(0, 3'b010, 3'b000, {3'd0, 3'd2, 3'd0}, {32'h0, 32'h1D02, 32'h0}, 5'b11011, 3'b000, 5'b00100, 5'b00000, tid(2, 1), at(2, 32'h1D01), 16'd0);
    add(0, 3'b010, 3'b000, {3'd0, 3'd2, 3'd0}, {32'h0, 32'h1D02, 32'h0}, 5'h1f,     3'b010, 5'b00100, 5'b00000, tid(2, 1), at(2, 32'h1D01), 16'd0);
    add(0, 3'b010, 3'b000, {3'd0, 3'd2, 3'd0}, {32'h0, 32'h1D03, 32'h0}, 5'h1f,     3'b010, 5'b00100, 5'b00000, tid(2, 1), at(2, 32'h1D02), 16'd0);
    add(0, 3'b010, 3'b010, {3'd0, 3'd2, 3'd0}, {32'h0, 32'h1D04, 32'h0}, 5'h1f,     3'b010, 5'b00100, 5'b00000, tid(2, 1), at(2, 32'h1D03), 16'd0);
    add(0, 3'b000, 3'b000, D444, '0,                                     5'h1f,     3'b000, 5'b00100, 5'b00100, tid(2, 1), at(2, 32'h1D04), 16'd0);
    // Locked route: in0 sends tdest 1,7,7; everything lands on out1.
    add(0, 3'b001, 3'b000, {3'd0, 3'd0, 3'd1}, {64'h0, 32'h0E01}, 5'h1f, 3'b001, 5'b00000, 5'b00000, 10'h0, '0, 16'd0);
    add(0, 3'b001, 3'b000, {3'd0, 3'd0, 3'd7}, {64'h0, 32'h0E02}, 5'h1f, 3'b001, 5'b00010, 5'b00000, tid(1, 0), at(1, 32'h0E01), 16'd0);
    add(0, 3'b001, 3'b001, {3'd0, 3'd0, 3'd7}, {64'h0, 32'h0E03}, 5'h1f, 3'b001, 5'b00010, 5'b00000, tid(1, 0), at(1, 32'h0E02), 16'd0);
    add(0, 3'b000, 3'b000, D444, '0,                               5'h1f, 3'b000, 5'b00010, 5'b00010, tid(1, 0), at(1, 32'h0E03), 16'd0);
    // Drop: in2 sends a 2-beat packet to tdest 6.
    add(0, 3'b100, 3'b000, {3'd6, 3'd0, 3'd0}, {32'h2F01, 64'h0}, 5'h1f, 3'b100, 5'b00000, 5'b00000, 10'h0, '0, 16'd0);
    add(0, 3'b100, 3'b100, {3'd6, 3'd0, 3'd0}, {32'h2F02, 64'h0}, 5'h1f, 3'b100, 5'b00000, 5'b00000, 10'h0, '0, 16'd0);
    add(0, 3'b000, 3'b000, D444, '0,                               5'h1f, 3'b000, 5'b00000, 5'b00000, 10'h0, '0, 16'd1);

    for (int k = 0; k < tbl.size(); k++) begin
      vec_t v;
      v = tbl[k];
      drive(v.rst, v.vld, v.lst, v.dst, v.dat, v.rdy);
      @(negedge clk);
      check($sformatf("row%0d s_tready", k), 160'(s_tready), 160'(v.e_srdy));
      check($sformatf("row%0d m_tvalid", k), 160'(m_tvalid), 160'(v.e_mvld));
      check($sformatf("row%0d drop_cnt", k), 160'(drop_cnt), 160'(v.e_drop));
      if (v.rst) begin
        check($sformatf("row%0d reset m_tdata", k), m_tdata, '0);
        check($sformatf("row%0d reset m_tid", k), 160'(m_tid), '0);
        check($sformatf("row%0d reset m_tlast", k), 160'(m_tlast), '0);
      end
      for (int j = 0; j < 5; j++)
        if (v.e_mvld[j]) begin
          check($sformatf("row%0d out%0d data", k, j), 160'(m_tdata[j*32 +: 32]), 160'(v.e_mdat[j*32 +: 32]));
          check($sformatf("row%0d out%0d tid", k, j), 160'(m_tid[j*2 +: 2]), 160'(v.e_mtid[j*2 +: 2]));
          check($sformatf("row%0d out%0d last", k, j), 160'(m_tlast[j]), 160'(v.e_mlast[j]));
        end
      @(posedge clk); #1;
    end

    // Saturation: three single-beat drops per cycle from drop_cnt=1.
    drive(1'b0, 3'b111, 3'b111, {3'd6, 3'd6, 3'd6}, '0, 5'h1f);
    @(negedge clk);
    check("sat s_tready", 160'(s_tready), 160'(3'b111));
    check("sat start drop_cnt", 160'(drop_cnt), 160'(16'd1));
    repeat (100) @(posedge clk);
    #1;
    check("sat drop_cnt after 100", 160'(drop_cnt), 160'(16'd301));
    repeat (21800) @(posedge clk);
    #1;
    check("sat drop_cnt at limit", 160'(drop_cnt), 160'(16'hFFFF));
    repeat (3) @(posedge clk);
    #1;
    check("sat drop_cnt held", 160'(drop_cnt), 160'(16'hFFFF));
    check("sat m_tvalid", 160'(m_tvalid), '0);

    // Reset mid-packet: in0 opens a packet to out3, reset, then a head beat to out0.
    drive(1'b0, 3'b001, 3'b000, {3'd0, 3'd0, 3'd3}, {64'h0, 32'h33}, 5'h1f);
    @(negedge clk);
    check("midrst head s_tready", 160'(s_tready), 160'(3'b001));
    @(posedge clk); #1;
    check("midrst out3 valid", 160'(m_tvalid), 160'(5'b01000));
    drive(1'b1, 3'b000, 3'b000, '0, '0, 5'h1f);
    @(posedge clk); #1;
    check("midrst m_tvalid", 160'(m_tvalid), '0);
    check("midrst drop_cnt", 160'(drop_cnt), '0);
    drive(1'b0, 3'b001, 3'b001, {3'd0, 3'd0, 3'd0}, {64'h0, 32'h44}, 5'h1f);
    @(negedge clk);
    check("midrst new head s_tready", 160'(s_tready), 160'(3'b001));
    @(posedge clk); #1;
    check("midrst new head m_tvalid", 160'(m_tvalid), 160'(5'b00001));
    check("midrst new head data", 160'(m_tdata[31:0]), 160'(32'h44));
    check("midrst new head tid", 160'(m_tid[1:0]), '0);
    drive(1'b0, 3'b000, 3'b000, '0, '0, 5'h1f);
    @(posedge clk); #1;
    check("midrst idle m_tvalid", 160'(m_tvalid), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_xbar_rr.md
Name: axis_xbar_rr

Overview:
- Parametrised AXI-Stream crossbar with S_COUNT input ports and M_COUNT output ports.
- Packets are routed by tdest. Each output runs an independent round-robin arbiter, and a packet holds its grant from the first beat until tlast.
- Each output has a registered pipeline stage. Packets whose tdest is out of range are discarded and counted.
- Successor to the fixed-behaviour streaming crossbar: adds fairness, packet locking, a source-ID sideband and drop accounting.

Parameters:
S_COUNT, 3, number of input ports (1..16)
M_COUNT, 5, number of output ports (1..16)
DATA_WIDTH, 32, tdata width per port
DEST_WIDTH, 3, tdest width; must be >= clog2(M_COUNT)
ID_WIDTH, 2, width of m_tid; must be >= clog2(S_COUNT)

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
s_tdata  in  S_COUNT*DATA_WIDTH  input data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
s_tvalid  in  S_COUNT  input valid
s_tready  out  S_COUNT  input ready
s_tlast  in  S_COUNT  last beat of packet
s_tdest  in  S_COUNT*DEST_WIDTH  destination output index
m_tdata  out  M_COUNT*DATA_WIDTH  output data
m_tvalid  out  M_COUNT  output valid (registered)
m_tready  in  M_COUNT  output ready
m_tlast  out  M_COUNT  output last
m_tid  out  M_COUNT*ID_WIDTH  index of the source input for the current beat
drop_cnt  out  16  saturating count of dropped packets

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: m_tvalid=0, m_tdata=0, m_tlast=0, m_tid=0, drop_cnt=0.
  - All input route locks and output owner locks are cleared.
  - Every round-robin pointer is set to S_COUNT-1, so input 0 has first priority.
  - s_tready is 0 while rst=1.
  - Reset mid-packet abandons the packet. No beat is emitted afterwards, and the next beat on that input is treated as a packet head.
- Transfer: a beat transfers when valid&&ready are both high at a clk edge. Signals are sampled at the edge.
- Input port state, one of IDLE or INPKT:
  - In IDLE, the route is s_tdest of the current beat (the head beat).
  - When a non-last head beat is accepted, the port latches route=s_tdest and moves to INPKT.
  - In INPKT, s_tdest is ignored and the latched route is used. An accepted beat with tlast returns the port to IDLE.
- Output stage j:
  - Has a free slot when m_tvalid[j]=0 or m_tready[j]=1.
  - State FREE or OWNED(owner).
  - In FREE: the requesters are inputs with s_tvalid=1 whose route equals j. The winner is the first requester found scanning from pointer+1 upward, modulo S_COUNT.
  - Winner ready: s_tready[winner] = free slot, asserted combinationally in the same cycle. All losers see s_tready=0.
  - In OWNED: only the owner can get ready, with s_tready = free slot. Other requesters wait.
- Output j lock and pointer:
  - An accepted non-last beat from FREE moves output j to OWNED(winner).
  - An accepted tlast beat moves output j to FREE and sets pointer=source index.
  - A single-beat packet also updates the pointer.
- Latency:
  - An accepted beat appears on m_t* on the next cycle, with m_tid=source index.
  - m_tvalid drops when m_tready=1 and no new beat is accepted that cycle.
  - Full throughput: one beat per cycle per output under continuous m_tready.
  - With m_tready held low, m_t* stay stable and the owner stalls.
- Invalid destination (route >= M_COUNT):
  - s_tready=1 for every beat of the packet; the data is discarded.
  - drop_cnt increments once per packet, on the tlast beat. It saturates at 0xFFFF.
- Parallelism:
  - Different outputs are independent; S_COUNT transfers may complete in one cycle to distinct outputs.
  - An input never drives two outputs in the same cycle.
- tvalid rules: tvalid must not deassert before the handshake; this is a source obligation. The crossbar never drops a beat whose route is valid.
- No combinational path from m_tready to m_tvalid. The path from m_tready to s_tready is allowed.

Test Plan:
- Reset: drive s_tvalid=3'b111 with rst=1 for 3 cycles -> s_tready=0, m_tvalid=0, drop_cnt=0 throughout. Release rst -> input 0 wins first.
- Round-robin: inputs 0, 1 and 2 each send 2-beat packets to output 4 back to back, with m_tready=1 -> m_tid sequence 0,0,1,1,2,2,0,0. Packets are never interleaved; 1-cycle latency from s handshake to m_tvalid.
- Parallel routing: in one cycle, in0->out0, in1->out3 and in2->out1 with single-beat packets 0xA0, 0xB3, 0xC1 -> next cycle m_tvalid=5'b01011 with matching data and tids 0, 1, 2.
- Backpressure: a 4-beat packet from in1 to out2 with m_tready[2] low for cycles 2-5 -> m_tdata is held stable, s_tready[1]=0 during the stall, and all 4 beats arrive in order with tlast only on beat 4.
- Lock with changing tdest: in0 sends 3 beats with tdest=1, 7, 7 -> all beats are delivered on out1 and drop_cnt stays 0.
- Drop: in2 sends a 2-beat packet with tdest=6 (M_COUNT=5) -> s_tready=1 on both beats, no m_tvalid, drop_cnt=1. Then 0xFFFF further drops -> drop_cnt saturates at 0xFFFF.
